// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: debug sequencer that owns the register-file read-A and
// write ports while it streams registers FIRST_REG..LAST_REG out (dump) or
// fills them from an input stream (load). The CPU is stalled while busy.
//
// Optional feature: define DUMP_CHECKSUM_EN to append one checksum beat
// (dump_addr = 0, dump_data = 32-bit wrapping sum of all dumped words)
// after the last register beat of a dump.
module regfile_dump_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start_dump,
    input  logic              start_load,
    input  logic              abort,
    output logic              busy,
    output logic              cpu_stall,
    output logic              done,
    output logic [ADDR_W-1:0] rf_A_addr,
    input  logic [DATA_W-1:0] rf_A_data,
    output logic [ADDR_W-1:0] rf_W_addr,
    output logic [DATA_W-1:0] rf_Data,
    output logic              rf_Write,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_valid,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP,
        S_LOAD,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    // Set once the LAST_REG beat has been captured; idx then parks on LAST_REG
    // so it never wraps to 0 while the port pair is owned.
    logic              issued_all;
    logic              slot_free;
    logic              last_acc;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0]       csum;
`endif

    // The read port address is the index register itself, so it is registered
    // and is only 0 while idle.
    assign rf_A_addr = idx;

    // Output slot can take a new beat when empty or being drained this edge.
    assign slot_free = !dump_valid || dump_ready;
    assign last_acc  = (state == S_DUMP) && dump_valid && dump_ready
                       && (dump_addr == LAST_A);

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and the combinational port-pair / status outputs.
    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        cpu_stall  = (state != S_IDLE);
        done       = (state == S_DONE);
        load_ready = 1'b0;
        rf_Write   = 1'b0;
        rf_W_addr  = '0;
        rf_Data    = '0;
        case (state)
            S_IDLE: begin
                if (start_dump)      state_nxt = S_DUMP;
                else if (start_load) state_nxt = S_LOAD;
            end
            S_DUMP: begin
`ifdef DUMP_CHECKSUM_EN
                if (last_acc) state_nxt = S_CSUM;
`else
                if (last_acc) state_nxt = S_DONE;
`endif
            end
            S_LOAD: begin
                load_ready = 1'b1;
                rf_Write   = load_valid;
                rf_W_addr  = idx;
                rf_Data    = load_data;
                if (load_valid && idx == LAST_A) state_nxt = S_DONE;
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (dump_valid && dump_ready) state_nxt = S_DONE;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Index counter, dump output slot and checksum accumulator.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            idx        <= '0;
            issued_all <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (abort) begin
            idx        <= '0;
            issued_all <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_dump || start_load) begin
                        idx        <= FIRST_A;
                        issued_all <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                S_DUMP: begin
                    if (slot_free) begin
                        if (!issued_all) begin
                            dump_data  <= rf_A_data;
                            dump_addr  <= idx;
                            dump_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            csum       <= csum + 32'(rf_A_data);
`endif
                            if (idx == LAST_A) issued_all <= 1'b1;
                            else               idx        <= idx + 1'b1;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            // Last register beat leaving: present the sum beat.
                            if (last_acc) begin
                                dump_data  <= DATA_W'(csum);
                                dump_addr  <= '0;
                                dump_valid <= 1'b1;
                            end else begin
                                dump_valid <= 1'b0;
                            end
`else
                            dump_valid <= 1'b0;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    if (load_valid && idx != LAST_A) idx <= idx + 1'b1;
                end
`ifdef DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (dump_ready) dump_valid <= 1'b0;
                end
`endif
                S_DONE: begin
                    idx        <= '0;
                    issued_all <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: a behavioural register file answers the
// port pair, a reference array holds the intended contents, and randomized
// load/dump sessions are checked beat by beat against it.
module tb_regfile_dump_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FR = 1;
    localparam int LR = 31;
    localparam int NREG = LR - FR + 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          start_dump = 1'b0;
    logic          start_load = 1'b0;
    logic          abort = 1'b0;
    logic          busy, cpu_stall, done;
    logic [AW-1:0] rf_A_addr;
    logic [DW-1:0] rf_A_data;
    logic [AW-1:0] rf_W_addr;
    logic [DW-1:0] rf_Data;
    logic          rf_Write;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;

    logic [DW-1:0] rf [0:31] = '{default: '0};
    logic [DW-1:0] ref_regs [0:31];
    logic [DW-1:0] load_vals [0:31];
    int            wr_cnt = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    regfile_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(FR), .LAST_REG(LR)) dut (
        .Clock(Clock), .Reset(Reset), .start_dump(start_dump), .start_load(start_load),
        .abort(abort), .busy(busy), .cpu_stall(cpu_stall), .done(done),
        .rf_A_addr(rf_A_addr), .rf_A_data(rf_A_data), .rf_W_addr(rf_W_addr),
        .rf_Data(rf_Data), .rf_Write(rf_Write), .dump_data(dump_data),
        .dump_addr(dump_addr), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready)
    );

    always #5 Clock = ~Clock;

    // Register file: combinational read, write on the clock edge.
    assign rf_A_data = rf[rf_A_addr];
    always @(posedge Clock) begin
        if (rf_Write) begin
            rf[rf_W_addr] <= rf_Data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rf(input string tag);
        int bad = 0;
        for (int i = FR; i <= LR; i++) if (rf[i] !== ref_regs[i]) bad++;
        chk(tag, bad, 0);
    endtask

    // mode 0: load_valid always high, 1: one cycle in three, 2: random
    task automatic do_load(input int mode, input bit fixed);
        int r, cyc, last_drv, w0;
        bit v, got_done;
        for (int i = FR; i <= LR; i++) load_vals[i] = fixed ? DW'(32'h100 + i) : DW'($urandom);
        w0 = wr_cnt; r = FR; last_drv = 0; got_done = 0; cyc = 0;
        @(negedge Clock) start_load = 1'b1;
        @(negedge Clock) start_load = 1'b0;
        while (cyc < 400) begin
            if (done) begin got_done = 1; break; end
            chk("load_ready", load_ready, 1);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (r > LR) v = 1'b0;
            load_valid = v;
            load_data  = v ? load_vals[r] : DW'($urandom);
            if (v) begin ref_regs[r] = load_vals[r]; r++; last_drv = cyc; end
            @(negedge Clock);
            cyc++;
        end
        load_valid = 1'b0;
        chk("load_done_seen", got_done, 1);
        chk("load_done_cyc", cyc, last_drv + 1);
        chk("load_writes", wr_cnt - w0, NREG);
        @(negedge Clock);
        chk("load_done_pulse", done, 0);
        chk("load_idle", busy, 0);
        chk_rf("load_rf_contents");
    endtask

    // mode 0: dump_ready always high, 1: toggling, 2: random
    task automatic do_dump(input int mode);
        int cyc, beat, stalls, nexp;
        bit held, got_done, rdy;
        logic [AW-1:0] h_addr, e_addr;
        logic [DW-1:0] h_data, e_data, sum;
        nexp = NREG;
`ifdef DUMP_CHECKSUM_EN
        nexp++;
`endif
        sum = '0;
        for (int i = FR; i <= LR; i++) sum = sum + ref_regs[i];
        cyc = 0; beat = 0; stalls = 0; held = 0; got_done = 0;
        h_addr = '0; h_data = '0;
        @(negedge Clock) begin start_dump = 1'b1; dump_ready = 1'b0; end
        @(negedge Clock) start_dump = 1'b0;
        chk("dump_busy", busy, 1);
        chk("dump_cpu_stall", cpu_stall, 1);
        while (cyc < 500) begin
            if (held) begin
                chk("dump_hold_valid", dump_valid, 1);
                chk("dump_hold_addr", dump_addr, h_addr);
                chk("dump_hold_data", dump_data, h_data);
            end
            held = 0;
            if (done) begin got_done = 1; break; end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dump_ready = rdy;
            if (dump_valid) begin
                if (rdy) begin
                    if (beat < NREG) begin
                        e_addr = AW'(FR + beat);
                        e_data = ref_regs[FR + beat];
                    end else begin
                        e_addr = '0;
                        e_data = sum;
                    end
                    chk("dump_addr", dump_addr, e_addr);
                    chk("dump_data", dump_data, e_data);
                    beat++;
                end else begin
                    stalls++; held = 1; h_addr = dump_addr; h_data = dump_data;
                end
            end
            @(negedge Clock);
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump_done_seen", got_done, 1);
        chk("dump_beats", beat, nexp);
        chk("dump_done_cyc", cyc, nexp + 1 + stalls);
        @(negedge Clock);
        chk("dump_done_pulse", done, 0);
        chk("dump_idle", busy, 0);
        chk("dump_idle_addr", rf_A_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;

        // Reset state
        #3 Reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_rf_write", rf_Write, 0);
        chk("rst_rf_a_addr", rf_A_addr, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        // Gapless load of 0x100+r, then dumps under different back-pressure
        do_load(0, 1'b1);
        do_dump(0);
        do_dump(1);

        // Gapped and random loads
        do_load(1, 1'b1);
        do_load(1, 1'b0);
        do_dump(2);

        // Priority: both starts -> dump; abort after beat 10
        @(negedge Clock) begin start_dump = 1'b1; start_load = 1'b1; dump_ready = 1'b1; end
        @(negedge Clock) begin start_dump = 1'b0; start_load = 1'b0; end
        chk("prio_busy", busy, 1);
        chk("prio_not_load", load_ready, 0);
        n = 0;
        while (!(dump_valid && dump_addr == AW'(10)) && n < 100) begin
            @(negedge Clock);
            n++;
        end
        chk("abort_reach10", dump_addr, 10);
        @(negedge Clock) abort = 1'b1;
        @(negedge Clock) begin abort = 1'b0; dump_ready = 1'b0; end
        chk("abort_busy", busy, 0);
        chk("abort_dump_valid", dump_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_rf_a_addr", rf_A_addr, 0);
        @(negedge Clock);
        chk("abort_no_done", done, 0);
        do_load(2, 1'b0);
        do_dump(0);

        // Reset in the middle of a dump
        @(negedge Clock) begin start_dump = 1'b1; dump_ready = 1'b1; end
        @(negedge Clock) start_dump = 1'b0;
        repeat (5) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_dump_valid", dump_valid, 0);
        chk("midrst_rf_write", rf_Write, 0);
        chk("midrst_load_ready", load_ready, 0);
        chk("midrst_rf_a_addr", rf_A_addr, 0);
        @(negedge Clock) begin Reset = 1'b1; dump_ready = 1'b0; end
        chk_rf("midrst_rf_intact");
        do_dump(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
# regfile_dump_ctrl

Debug/bring-up sequencer that drives the register-file port pair from the initiator side. It streams every architectural register (1..31) out over a valid/ready channel (dump) or fills every register from an input valid/ready channel (load). It sits between the debug interface and the register file, muxed onto the read-A and write ports, and holds the CPU stalled while it owns them.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width
- FIRST_REG, 1, first register visited
- LAST_REG, 31, last register visited (FIRST_REG <= LAST_REG)

Ports (reset Reset, asynchronous, active-low; clock Clock):
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous active-low reset
- start_dump  in  1  request dump, sampled in IDLE only
- start_load  in  1  request load, sampled in IDLE only
- abort  in  1  synchronous abort of any operation
- busy  out  1  state != IDLE
- cpu_stall  out  1  equals busy
- done  out  1  one-cycle pulse on completion
- rf_A_addr  out  ADDR_W  register-file read address (registered)
- rf_A_data  in  DATA_W  register-file read data (combinational from rf_A_addr)
- rf_W_addr  out  ADDR_W  write address
- rf_Data  out  DATA_W  write data
- rf_Write  out  1  write enable
- dump_data  out  DATA_W  dump beat data
- dump_addr  out  ADDR_W  register number of dump beat
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  dump beat accepted
- load_data  in  DATA_W  load beat data
- load_valid  in  1  load beat valid
- load_ready  out  1  load beat accepted

## Operation
- States: IDLE, DUMP, LOAD, CSUM (only with macro), DONE. Index counter idx (ADDR_W bits).
- Reset: state IDLE, idx=0, every output 0.
- IDLE: start_dump -> DUMP; else start_load -> LOAD (dump wins if both). On entry idx=rf_A_addr=FIRST_REG. Starts outside IDLE ignored.
- DUMP: slot free when !dump_valid || dump_ready. While idx <= LAST_REG and slot free: dump_data<=rf_A_data, dump_addr<=idx, dump_valid<=1, idx/rf_A_addr increment. Slot free with nothing left: dump_valid<=0. Once the LAST_REG beat is accepted -> DONE (CSUM with macro).
- dump_data/dump_addr stable while dump_valid && !dump_ready.
- LOAD: load_ready=1. rf_Write = load_valid (combinational), rf_W_addr=idx, rf_Data=load_data; the register file writes on the handshake edge. idx increments per handshake; handshake at LAST_REG -> DONE. Gaps in load_valid stall without writes.
- rf_W_addr, rf_Data, rf_Write are 0 outside LOAD.
- DONE: done=1 one cycle, then IDLE.
- abort (any non-IDLE state): next edge -> IDLE, dump_valid and rf_Write drop, no done pulse. abort outranks all other events.
- idx is never 0 in DUMP/LOAD; rf_A_addr=0 only in IDLE.

## Timing
- DUMP entered at edge k: beat for register r visible after edge k+(r-FIRST_REG+1) when dump_ready is held high; with defaults, last beat after k+31, accepted at k+32, done high between k+32 and k+33.
- LOAD with load_valid held high: 31 consecutive writes, one per cycle, done on the cycle after the last write.
- Back-pressure adds exactly one cycle per cycle of dump_ready low with dump_valid high.
- Reset asserted mid-operation: immediate IDLE; partial load leaves already-written registers written.

## Configuration
- DUMP_CHECKSUM_EN defined: 32-bit wrapping sum of every captured dump_data (cleared on DUMP entry). After the LAST_REG beat is accepted, CSUM presents one extra beat with dump_addr=0 and dump_data=sum; its acceptance -> DONE.
- Undefined: CSUM state and accumulator absent; DUMP goes directly to DONE; dump_addr is never 0 while dump_valid is high.

## Test plan
- Reset check: Reset low mid-DUMP -> busy, done, dump_valid, rf_Write, load_ready, and rf_A_addr all 0 immediately.
- Load then dump, default params: load 0x100+r for r=1..31 with load_valid high -> 31 rf_Write pulses, one done. Dump with dump_ready high -> 31 beats, dump_addr 1..31, dump_data 0x100+dump_addr, done 32 cycles after DUMP entry.
- Back-pressure: toggle dump_ready every cycle -> no beat lost or duplicated, data stable while stalled, total 62 cycles to last acceptance.
- Load gaps: load_valid high one cycle in three -> writes only on handshakes, register contents identical to gapless case.
- Priority/abort: start_dump and start_load together -> DUMP. Assert abort after beat 10 -> IDLE next cycle, no done. A following start_load is honoured.
- Checksum (DUMP_CHECKSUM_EN): after the load above, the 32nd beat has dump_addr=0, dump_data=0x000020F0.
